muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, funct3 encodings and FSM state type for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] NEG_ONE   = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-division step.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;

    // Multiply: {high partial, remaining multiplier bits}; add on LSB, then shift right.
    // Divide: {partial remainder, dividend/quotient bits}; shift left, trial-subtract.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff      = rem_shift - {1'b0, operand};
        if (!diff[XLEN]) begin
            div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
        acc_next = is_div ? div_next : mul_next;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with stall handshake to the core.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single combinational multiply (done at cycle 1).
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import muldiv_pkg::*;

    state_t            state, state_next;
    logic [2:0]        f3;
    logic [2*XLEN-1:0] acc, acc_step, prod;
    logic [XLEN-1:0]   opd;
    logic              neg;
    logic [31:0]       cnt;

    logic              is_div, a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
    logic              div0, ovf, fast_hit;
    logic [XLEN-1:0]   early_res, fast_res, fin_res;

    // Request decode: MUL is treated as signed; its low half is sign-agnostic anyway.
    always_comb begin
        is_div    = funct3[2];
        a_sgn     = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
        b_sgn     = a_sgn && (funct3 != F3_MULHSU);
        a_neg     = a_sgn & op_a[XLEN-1];
        b_neg     = b_sgn & op_b[XLEN-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;
        neg_in    = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
        div0      = is_div && (op_b == '0);
        ovf       = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (op_a == INT_MIN) && (op_b == NEG_ONE);
        if (div0) begin
            early_res = funct3[1] ? op_a : DIV0_QUOT;
        end else begin
            early_res = funct3[1] ? '0 : INT_MIN;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
    always_comb begin
        fast_a   = {{XLEN{a_sgn & op_a[XLEN-1]}}, op_a};
        fast_b   = {{XLEN{b_sgn & op_b[XLEN-1]}}, op_b};
        fast_p   = fast_a * fast_b;
        fast_res = (funct3 == F3_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
        fast_hit = ~funct3[2];
    end
`else
    assign fast_res = '0;
    assign fast_hit = 1'b0;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc      (acc),
        .operand  (opd),
        .is_div   (f3[2]),
        .acc_next (acc_step)
    );

    // Sign fix is applied to the final iteration's output as it is written to result.
    always_comb begin
        prod = neg ? -acc_step : acc_step;
        quo  = neg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = neg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        if (f3[2]) begin
            fin_res = f3[1] ? rem : quo;
        end else begin
            fin_res = (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (div0 || ovf || fast_hit) ? DONE : CALC;
                end
            end
            CALC: begin
                if (!start) begin
                    state_next = IDLE;
                end else if (cnt == 32'd31) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            f3     <= '0;
            acc    <= '0;
            opd    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        f3  <= funct3;
                        neg <= neg_in;
                        cnt <= '0;
                        acc <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                        opd <= is_div ? b_mag : a_mag;
                        if (div0 || ovf) begin
                            result <= early_res;
                        end else if (fast_hit) begin
                            result <= fast_res;
                        end
                    end
                end
                CALC: begin
                    if (start) begin
                        acc <= acc_step;
                        cnt <= cnt + 32'd1;
                        if (cnt == 32'd31) begin
                            result <= fin_res;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall = start & ~done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: behavioural RV32M model, cycle-accurate done/stall/result checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, done;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    int          checks = 0;
    int          errors = 0;
    bit          active = 1'b0;
    bit          exp_done;
    int          cyc = 0;
    int          lat = 0;
    logic [31:0] exp_res = '0;
    logic [31:0] held_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub_s;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        ub_s = ub;
        r    = '0;
        case (f)
            3'd0: begin p = sa * sb;   r = p[31:0];  end
            3'd1: begin p = sa * sb;   r = p[63:32]; end
            3'd2: begin p = sa * ub_s; r = p[63:32]; end
            3'd3: begin p = ua * ub;   r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 1;
            if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Compare process: done exactly at the modelled cycle, stall = start & !done, result held otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            exp_done = active && (cyc == lat);
            chk("done", {31'b0, done}, {31'b0, exp_done});
            chk("stall", {31'b0, stall}, {31'b0, start && !exp_done});
            if (exp_done) begin
                chk("result", result, exp_res);
                held_res = exp_res;
                active   = 1'b0;
            end else begin
                chk("result_hold", result, held_res);
            end
            if (active) cyc++;
        end
    end

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3  = f;
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        exp_res = model(f, a, b);
        lat     = model_lat(f, a, b);
        cyc     = 0;
        active  = 1'b1;
    endtask

    // Operands are scrambled after cycle 0 to confirm they are sampled only in IDLE.
    task automatic wait_done();
        int n;
        n = 0;
        while (active && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (active && cyc > 0) begin
                op_a = $urandom;
                op_b = $urandom;
            end
        end
        if (active) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen after %0d cycles, expected latency %0d", n, lat);
            active = 1'b0;
            start  = 1'b0;
        end
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
        start_op(f, a, b);
        chk("model_pin", exp_res, lit);
        wait_done();
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    logic [2:0]  d_f   [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'd42, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef MULDIV_FAST_MUL_EN
        chk("lat_mul", model_lat(3'd0, 32'd7, 32'd6), 32'd1);
`else
        chk("lat_mul", model_lat(3'd0, 32'd7, 32'd6), 32'd33);
`endif
        chk("lat_div0", model_lat(3'd4, 32'd5, 32'd0), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run(d_f[i], d_a[i], d_b[i], d_exp[i]);
            repeat (2) @(posedge clk);
            #1;
        end

        // Abort at CALC cycle 10: no done, result keeps the previous value.
        run(3'd0, 32'd7, 32'd6, 32'd42);
        @(posedge clk);
        #1;
        start_op(3'd5, 32'd1000, 32'd3);
        wait_cyc(10);
        start  = 1'b0;
        active = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        run(3'd5, 32'd100, 32'd7, 32'd14);
        @(posedge clk);
        #1;

        // Reset mid-CALC clears result and done immediately.
        start_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_cyc(20);
        #2;
        rst    = 1'b1;
        start  = 1'b0;
        active = 1'b0;
        #1;
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        held_res = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;

        // Reset held across the edge that would enter DONE.
        start_op(3'd0, 32'd9, 32'd9);
        wait_cyc(32);
        active = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_done_result", result, 32'd0);
        chk("rst_done_done", {31'b0, done}, 32'd0);
        start    = 1'b0;
        held_res = '0;
        rst      = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back: second request seen the cycle after DONE, completes at cycle 67.
        start_op(3'd0, 32'd7, 32'd6);
        wait_done();
        start_op(3'd5, 32'd100, 32'd7);
        wait_done();
        start = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            start_op(f, a, b);
            wait_done();
            if ($urandom_range(0, 1) == 0) begin
                start = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
